// File: rtl/vpu_pkg.sv
// Shared parameters and types for the VPU operand source port.
package vpu_pkg;

    localparam int OPERAND_WIDTH   = 16;
    localparam int SRAM_R_PORT_CNT = 3;
    localparam int ADDR_WIDTH      = 12;
    localparam int CNT_WIDTH       = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } src_state_t;

    typedef logic [SRAM_R_PORT_CNT-1:0][OPERAND_WIDTH-1:0] op_vec_t;
    typedef logic [SRAM_R_PORT_CNT-1:0][ADDR_WIDTH-1:0]    addr_vec_t;

    typedef struct packed {
        op_vec_t op;
    } op_triple_t;

    // Unused operand slots are stored as zero so the consumer sees clean data.
    function automatic op_triple_t mask_ops(
        op_vec_t                    d,
        logic [SRAM_R_PORT_CNT-1:0] m
    );
        op_triple_t t;
        t = '0;
        for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
            t.op[p] = m[p] ? d[p] : '0;
        end
        return t;
    endfunction

endpackage

// File: rtl/vpu_src_port_if.sv
// SRAM read bus plus operand valid/ready bus of the VPU source port.
interface vpu_src_port_if;
    import vpu_pkg::*;

    logic [SRAM_R_PORT_CNT-1:0] sram_rd_en;
    addr_vec_t                  sram_rd_addr;
    op_vec_t                    sram_rd_data;
    logic [OPERAND_WIDTH-1:0]   op_0;
    logic [OPERAND_WIDTH-1:0]   op_1;
    logic [OPERAND_WIDTH-1:0]   op_2;
    logic [SRAM_R_PORT_CNT-1:0] op_valid;
    logic                       valid;
    logic                       ready;
    logic                       last;

    modport master (
        output sram_rd_en, sram_rd_addr,
        input  sram_rd_data,
        output op_0, op_1, op_2, op_valid, valid, last,
        input  ready
    );

    modport slave (
        input  sram_rd_en, sram_rd_addr,
        output sram_rd_data,
        input  op_0, op_1, op_2, op_valid, valid, last,
        output ready
    );

endinterface

// File: rtl/vpu_src_fifo.sv
// Two-entry synchronous FIFO of operand triples with occupancy output.
module vpu_src_fifo
    import vpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  op_triple_t wr_data_i,
    input  logic       rd_en_i,
    output op_triple_t rd_data_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    op_triple_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (rd_en_i) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            unique case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == 2'd0);
    assign count_o   = count_q;

endmodule

// File: rtl/vpu_src_port.sv
// VPU operand source port: SRAM element reads -> operand triples.
// Optional per-port stride input enabled by VPU_SRC_STRIDE_EN.
module vpu_src_port
    import vpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [SRAM_R_PORT_CNT-1:0] src_mask_i,
    input  addr_vec_t                  base_addr_i,
    input  logic [CNT_WIDTH-1:0]       elem_cnt_i,
`ifdef VPU_SRC_STRIDE_EN
    input  addr_vec_t                  stride_i,
`endif
    output logic                       busy_o,
    output logic                       done_o,
    vpu_src_port_if.master             src_if
);

    src_state_t                 state_q, state_d;
    logic [SRAM_R_PORT_CNT-1:0] mask_q, mask_d;
    addr_vec_t                  addr_q, addr_d;
    addr_vec_t                  stride;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]       issued_q, issued_d;
    logic [CNT_WIDTH-1:0]       popped_q, popped_d;
    logic [CNT_WIDTH-1:0]       cnt_m1;
    logic                       inflight_q;
    logic                       done_q, done_d;

    logic [1:0]                 fifo_cnt;
    logic                       fifo_empty;
    op_triple_t                 fifo_head;
    op_triple_t                 fifo_wdata;
    logic                       pop;
    logic                       issue;
    logic                       last_elem;
    logic [2:0]                 occ;
    logic [SRAM_R_PORT_CNT-1:0] rd_en;

`ifdef VPU_SRC_STRIDE_EN
    addr_vec_t stride_q, stride_d;
    assign stride = stride_q;
`else
    always_comb begin
        for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
            stride[p] = ADDR_WIDTH'(1);
        end
    end
`endif

    assign cnt_m1    = cnt_q - CNT_WIDTH'(1);
    assign pop       = !fifo_empty && src_if.ready;
    assign last_elem = (popped_q == cnt_m1);

    // Slots already promised: buffered + returning next edge - leaving now.
    assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == ISSUE) && (occ < 3'd2);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        popped_d = popped_q;
        done_d   = 1'b0;
`ifdef VPU_SRC_STRIDE_EN
        stride_d = stride_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mask_d   = src_mask_i;
                    addr_d   = base_addr_i;
                    cnt_d    = elem_cnt_i;
                    issued_d = '0;
                    popped_d = '0;
`ifdef VPU_SRC_STRIDE_EN
                    stride_d = stride_i;
`endif
                    if (elem_cnt_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    issued_d = issued_q + CNT_WIDTH'(1);
                    for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
                        addr_d[p] = addr_q[p] + stride[p];
                    end
                    if (issued_q == cnt_m1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last_elem) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            popped_d = popped_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef VPU_SRC_STRIDE_EN
            stride_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= issue;
            done_q     <= done_d;
`ifdef VPU_SRC_STRIDE_EN
            stride_q   <= stride_d;
`endif
        end
    end

    assign fifo_wdata = mask_ops(src_if.sram_rd_data, mask_q);

    vpu_src_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    always_comb begin
        rd_en = issue ? mask_q : '0;
        src_if.sram_rd_en = rd_en;
        for (int p = 0; p < SRAM_R_PORT_CNT; p++) begin
            src_if.sram_rd_addr[p] = rd_en[p] ? addr_q[p] : '0;
        end
    end

    always_comb begin
        src_if.valid    = !fifo_empty;
        src_if.op_0     = fifo_empty ? '0 : fifo_head.op[0];
        src_if.op_1     = fifo_empty ? '0 : fifo_head.op[1];
        src_if.op_2     = fifo_empty ? '0 : fifo_head.op[2];
        src_if.op_valid = fifo_empty ? '0 : mask_q;
        src_if.last     = !fifo_empty && last_elem;
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_vpu_src_port.sv
// Self-checking bench for vpu_src_port with a queue-free index model.
module tb_vpu_src_port;
    import vpu_pkg::*;

    localparam int P = SRAM_R_PORT_CNT;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_i = 1'b0;
    logic [P-1:0]         src_mask_i = '0;
    addr_vec_t            base_addr_i = '0;
    logic [CNT_WIDTH-1:0] elem_cnt_i = '0;
`ifdef VPU_SRC_STRIDE_EN
    addr_vec_t            stride_i = '0;
`endif
    logic                 busy_o;
    logic                 done_o;

    vpu_src_port_if bus();

    vpu_src_port dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .src_mask_i  (src_mask_i),
        .base_addr_i (base_addr_i),
        .elem_cnt_i  (elem_cnt_i),
`ifdef VPU_SRC_STRIDE_EN
        .stride_i    (stride_i),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .src_if      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] dat(int p, logic [11:0] a);
        logic [1:0] pp;
        pp = 2'(p + 1);
        return {pp, 2'b10, a};
    endfunction

    // SRAM: synchronous read, data valid the cycle after rd_en
    always @(posedge clk) begin
        for (int p = 0; p < P; p++) begin
            if (bus.sram_rd_en[p]) begin
                bus.sram_rd_data[p] <= dat(p, bus.sram_rd_addr[p]);
            end
        end
    end

    logic [P-1:0] m_mask = '0;
    int           m_cnt = 0;
    int           m_base [P];
    int           m_stride [P];
    int           job_id = 0;
    bit           chk_en = 1'b0;

    function automatic logic [11:0] exp_addr(int p, int i);
        int t;
        t = m_base[p] + i * m_stride[p];
        return t[11:0];
    endfunction

    function automatic logic [15:0] exp_op(int p, int i);
        if (!m_mask[p]) return 16'h0;
        return dat(p, exp_addr(p, i));
    endfunction

    int          seen_job = 0;
    int          issue_i = 0;
    int          pop_i = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_acc = 0;
    logic [11:0] addr_log [$];
    logic [15:0] op_log [$];
    bit          stall_q = 1'b0;
    logic [63:0] stall_vec = '0;
    logic [63:0] cur_vec;

    always @(negedge clk) begin
        if (seen_job != job_id) begin
            seen_job = job_id;
            issue_i  = 0;
            pop_i    = 0;
            stall_q  = 1'b0;
            addr_log.delete();
            op_log.delete();
        end
        if (chk_en) begin
            cur_vec = {11'b0, bus.valid, bus.op_0, bus.op_1,
                       bus.op_2, bus.op_valid, bus.last};
            if (bus.sram_rd_en != '0) begin
                chk("rd_en_mask", 64'(bus.sram_rd_en), 64'(m_mask));
                chk("rd_in_range", 64'(issue_i < m_cnt), 64'd1);
                for (int p = 0; p < P; p++) begin
                    chk("rd_addr", 64'(bus.sram_rd_addr[p]),
                        m_mask[p] ? 64'(exp_addr(p, issue_i)) : 64'd0);
                end
                addr_log.push_back(bus.sram_rd_addr[0]);
                issue_i++;
            end else begin
                chk("rd_addr_idle", 64'(bus.sram_rd_addr), 64'd0);
            end
            if (stall_q) chk("hold_on_stall", cur_vec, stall_vec);
            if (bus.valid) begin
                chk("valid_in_range", 64'(pop_i < m_cnt), 64'd1);
                chk("op_0", 64'(bus.op_0), 64'(exp_op(0, pop_i)));
                chk("op_1", 64'(bus.op_1), 64'(exp_op(1, pop_i)));
                chk("op_2", 64'(bus.op_2), 64'(exp_op(2, pop_i)));
                chk("op_valid", 64'(bus.op_valid), 64'(m_mask));
                chk("last", 64'(bus.last), 64'(pop_i == m_cnt - 1));
                if (bus.ready) begin
                    op_log.push_back(bus.op_0);
                    pop_i++;
                end
            end else begin
                chk("idle_ops", cur_vec, 64'd0);
            end
            stall_q   = bus.valid && !bus.ready;
            stall_vec = cur_vec;
            chk("outstanding", 64'(issue_i - pop_i <= 2), 64'd1);
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk_reset();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_rd_en", 64'(bus.sram_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(bus.sram_rd_addr), 64'd0);
        chk("rst_op_0", 64'(bus.op_0), 64'd0);
        chk("rst_op_1", 64'(bus.op_1), 64'd0);
        chk("rst_op_2", 64'(bus.op_2), 64'd0);
        chk("rst_op_valid", 64'(bus.op_valid), 64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_last", 64'(bus.last), 64'd0);
    endtask

    task automatic load_job(logic [P-1:0] mask, int b0, int b1, int b2,
                            int s0, int s1, int s2, int n);
        m_mask = mask;
        m_cnt  = n;
        m_base = '{b0, b1, b2};
`ifdef VPU_SRC_STRIDE_EN
        m_stride = '{s0, s1, s2};
        stride_i = {12'(s2), 12'(s1), 12'(s0)};
`else
        m_stride = '{1, 1, 1};
`endif
        job_id++;
        src_mask_i  = mask;
        base_addr_i = {12'(b2), 12'(b1), 12'(b0)};
        elem_cnt_i  = 10'(n);
        start_i     = 1'b1;
    endtask

    task automatic run_job(logic [P-1:0] mask, int b0, int b1, int b2,
                           int s0, int s1, int s2, int n,
                           int rmode, bit poke);
        int acc;
        int d0;
        bit got;
        @(posedge clk); #1;
        load_job(mask, b0, b1, b2, s0, s1, s2, n);
        bus.ready = (rmode == 0);
        acc = cyc + 1;
        last_acc = acc;
        d0 = done_cnt;
        got = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(n != 0));
        for (int k = 0; k < 8 * n + 40; k++) begin
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
            bus.ready = (rmode == 0) ? 1'b1 : k[0];
            if (poke && k == 2) begin
                start_i     = 1'b1;
                src_mask_i  = '1;
                base_addr_i = '1;
                elem_cnt_i  = 10'd7;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        if (rmode == 0) begin
            chk("done_latency", 64'(done_cyc - acc),
                64'((n == 0) ? 0 : n + 2));
        end
        chk("issued_all", 64'(issue_i), 64'(n));
        chk("popped_all", 64'(pop_i), 64'(n));
        @(negedge clk);
        chk("done_pulse_1cyc", 64'(done_o), 64'd0);
        chk("busy_dropped", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        m_cnt = 0;
        job_id++;
        chk_en = 1'b1;

        // two ports, ready held high
        run_job(3'b011, 'h010, 'h020, 0, 1, 1, 1, 4, 0, 1'b0);
        chk("t1_n_addr", 64'(addr_log.size()), 64'd4);
        chk("t1_addr0", 64'(addr_log[0]), 64'h010);
        chk("t1_addr3", 64'(addr_log[3]), 64'h013);
        chk("t1_op0_first", 64'(op_log[0]), 64'h6010);
        chk("t1_op0_last", 64'(op_log[3]), 64'h6013);
        chk("t1_done_at", 64'(done_cyc - last_acc), 64'd6);

        // all ports, ready toggling, start poked while busy
        run_job(3'b111, 'h200, 'h300, 'h400, 1, 1, 1, 8, 1, 1'b1);
        chk("t2_n_pops", 64'(op_log.size()), 64'd8);

        // zero-length descriptor
        run_job(3'b111, 5, 6, 7, 1, 1, 1, 0, 0, 1'b0);
        chk("t3_no_rd", 64'(addr_log.size()), 64'd0);
        chk("t3_done_at", 64'(done_cyc - last_acc), 64'd0);

        // address wrap
        run_job(3'b001, 'hFFE, 0, 0, 1, 1, 1, 4, 0, 1'b0);
        chk("t4_n_addr", 64'(addr_log.size()), 64'd4);
        chk("t4_addr0", 64'(addr_log[0]), 64'hFFE);
        chk("t4_addr1", 64'(addr_log[1]), 64'hFFF);
        chk("t4_addr2", 64'(addr_log[2]), 64'h000);
        chk("t4_addr3", 64'(addr_log[3]), 64'h001);

        // reset with FIFO full mid-ISSUE
        @(posedge clk); #1;
        load_job(3'b111, 'h040, 'h050, 'h060, 1, 1, 1, 8);
        bus.ready = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_issued", 64'(issue_i), 64'd2);
        chk("t5_valid", 64'(bus.valid), 64'd1);
        chk("t5_busy", 64'(busy_o), 64'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset();
        rst = 1'b0;
        m_cnt = 0;
        job_id++;
        chk_en = 1'b1;
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_job(3'b101, 'h070, 'h080, 'h090, 1, 1, 1, 3, 0, 1'b0);
        chk("t5_n_pops", 64'(op_log.size()), 64'd3);
        chk("t5_op0_first", 64'(op_log[0]), 64'h6070);

`ifdef VPU_SRC_STRIDE_EN
        run_job(3'b001, 'h100, 0, 0, 4, 1, 1, 3, 0, 1'b1);
        chk("t6_n_addr", 64'(addr_log.size()), 64'd3);
        chk("t6_addr0", 64'(addr_log[0]), 64'h100);
        chk("t6_addr1", 64'(addr_log[1]), 64'h104);
        chk("t6_addr2", 64'(addr_log[2]), 64'h108);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
